// File: rtl/pixel_scan_driver_pkg.sv
// Shared raytracer constants: default resolution, capture latency and the
// scan FSM state type used by pixel_scan_driver.
package pixel_scan_driver_pkg;

    localparam int H_RES_DEFAULT       = 320;
    localparam int V_RES_DEFAULT       = 240;
    localparam int CAPTURE_LAT_DEFAULT = 20;

    localparam int COORD_W = 10;
    localparam int LAT_W   = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_HOLD  = S_HOLD
    } scan_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position for one frame, with the end-of-line and
// last-pixel flags decoded from the current position.
module raster_counter
    import pixel_scan_driver_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               end_of_line,
    output logic               last_pixel
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

    logic [COORD_W-1:0] x_d, x_q;
    logic [COORD_W-1:0] y_d, y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + ONE;
            end else begin
                x_d = x_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign end_of_line = (x_q == X_MAX);
    assign last_pixel  = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/pixel_scan_driver.sv
// Walks a frame in raster order, issuing one raytracer request at a time and
// presenting each captured colour on a valid/ready output port.
module pixel_scan_driver
    import pixel_scan_driver_pkg::*;
#(
    parameter int H_RES       = H_RES_DEFAULT,
    parameter int V_RES       = V_RES_DEFAULT,
    parameter int CAPTURE_LAT = CAPTURE_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic [7:0]         rgb_r,
    input  logic [7:0]         rgb_g,
    input  logic [7:0]         rgb_b,
    output logic [7:0]         out_r,
    output logic [7:0]         out_g,
    output logic [7:0]         out_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eol,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CAPTURE_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    // out_valid/out_ready: a pixel transfers on any cycle both are high;
    // while out_valid is high and out_ready low, every out_* field holds.
    scan_state_e        state_d, state_q;
    logic [LAT_W-1:0]   lat_d, lat_q;
    logic               out_valid_d, out_valid_q;
    logic [7:0]         out_r_d, out_r_q;
    logic [7:0]         out_g_d, out_g_q;
    logic [7:0]         out_b_d, out_b_q;
    logic               out_sof_d, out_sof_q;
    logic               out_eol_d, out_eol_q;

    logic [COORD_W-1:0] cur_x, cur_y;
    logic               end_of_line, last_pixel;
    logic               accept, handshake, advance;

    assign accept    = (state_q == ST_IDLE) && frame_start;
    assign handshake = (state_q == ST_HOLD) && out_valid_q && out_ready;
    assign advance   = handshake && !last_pixel;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept),
        .advance     (advance),
        .x           (cur_x),
        .y           (cur_y),
        .end_of_line (end_of_line),
        .last_pixel  (last_pixel)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_g_d     = out_g_q;
        out_b_d     = out_b_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                lat_d   = '0;
            end
            ST_WAIT: begin
                // The sample cycle lands CAPTURE_LAT cycles after the request.
                if (lat_q == LAT_LAST) begin
                    out_r_d     = rgb_r;
                    out_g_d     = rgb_g;
                    out_b_d     = rgb_b;
                    out_sof_d   = (cur_x == '0) && (cur_y == '0);
                    out_eol_d   = end_of_line;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = last_pixel ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign pixel_x     = cur_x;
    assign pixel_y     = cur_y;
    assign pixel_valid = (state_q == ST_ISSUE);
    assign out_valid   = out_valid_q;
    assign out_r       = out_r_q;
    assign out_g       = out_g_q;
    assign out_b       = out_b_q;
    assign out_sof     = out_sof_q;
    assign out_eol     = out_eol_q;
    assign busy        = (state_q != ST_IDLE);
    // The closing handshake cycle is still in HOLD, so a coincident
    // frame_start cannot be taken.
    assign frame_done  = handshake && last_pixel;

endmodule

// File: tb/tb_pixel_scan_driver.sv
// Bench for pixel_scan_driver: a 4x2 instance against a cycle-level
// behavioural model, plus a full-width 320-pixel instance at minimum latency.
`timescale 1ns/1ps
module tb_pixel_scan_driver;
    import pixel_scan_driver_pkg::*;

    localparam int AH = 4, AV = 2, ALAT = 20;
    localparam int BH = H_RES_DEFAULT, BV = 3, BLAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, frame_start, out_ready, frame_start_b, out_ready_b;
    logic [7:0] rgb_r, rgb_g, rgb_b;
    assign rgb_r = cyc[7:0];
    assign rgb_g = cyc[7:0] ^ 8'h5A;
    assign rgb_b = ~cyc[7:0];

    logic [9:0] pixel_x, pixel_y, pixel_x_b, pixel_y_b;
    logic [7:0] out_r, out_g, out_b, out_r_b, out_g_b, out_b_b;
    logic pixel_valid, out_valid, out_sof, out_eol, busy, frame_done;
    logic pixel_valid_b, out_valid_b, out_sof_b, out_eol_b, busy_b, frame_done_b;

    pixel_scan_driver #(.H_RES(AH), .V_RES(AV), .CAPTURE_LAT(ALAT)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol),
        .busy(busy), .frame_done(frame_done)
    );

    pixel_scan_driver #(.H_RES(BH), .V_RES(BV), .CAPTURE_LAT(BLAT)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .pixel_valid(pixel_valid_b),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .out_r(out_r_b), .out_g(out_g_b), .out_b(out_b_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sof(out_sof_b), .out_eol(out_eol_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    // ---------------- checking ----------------
    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] col(input int c);
        logic [7:0] v;
        v = c[7:0];
        return {v, v ^ 8'h5A, ~v};
    endfunction

    // ---------------- reference model + scoreboard (4x2 instance) ----------------
    logic [25:0] exp_q[$];        // {sof, eol, r, g, b} per issued pixel
    bit m_en = 0, m_active = 0, m_pending = 0, m_after_rst = 0;
    int m_idx = 0, m_issue = 0, m_next_issue = 0, m_frames = 0;
    int frame_hs = 0, dut_fd_cnt = 0;

    always @(negedge clk) begin : model_a
        logic e_pv, e_ov, e_last;
        logic [25:0] e_out;
        e_pv = 1'b0; e_ov = 1'b0; e_last = 1'b0;
        if (m_en) begin
            e_pv   = m_active && (cyc == m_next_issue);
            e_ov   = m_active && m_pending && (cyc >= m_issue + ALAT + 1);
            e_last = (m_idx == AH * AV - 1);
            check("busy", busy, m_active);
            check("pixel_valid", pixel_valid, e_pv);
            check("out_valid", out_valid, e_ov);
            check("frame_done", frame_done, e_ov && out_ready && e_last);
            if (m_active) begin
                check("pixel_x", pixel_x, m_idx % AH);
                check("pixel_y", pixel_y, m_idx / AH);
            end
            if (e_ov && exp_q.size() > 0) begin
                e_out = exp_q[0];
                check("out_rgb", {out_r, out_g, out_b}, e_out[23:0]);
                check("out_sof", out_sof, e_out[25]);
                check("out_eol", out_eol, e_out[24]);
            end
            if (m_after_rst) begin
                check("rst_rgb", {out_r, out_g, out_b}, 0);
                check("rst_sof_eol", {out_sof, out_eol}, 0);
                check("rst_xy", {pixel_x, pixel_y}, 0);
            end
        end
        if (frame_done === 1'b1) dut_fd_cnt++;
        if (rst_n && out_valid === 1'b1 && out_ready) frame_hs++;
        if (!rst_n) begin
            m_en = 1; m_active = 0; m_pending = 0; m_after_rst = 1;
            exp_q.delete();
        end else if (m_en) begin
            m_after_rst = 0;
            if (m_active) begin
                if (e_pv) begin
                    m_pending = 1;
                    m_issue = cyc;
                    exp_q.push_back({m_idx == 0, (m_idx % AH) == AH - 1, col(cyc + ALAT)});
                end
                if (e_ov && out_ready) begin
                    void'(exp_q.pop_front());
                    m_pending = 0;
                    if (e_last) begin
                        m_active = 0;
                        m_frames++;
                    end else begin
                        m_idx++;
                        m_next_issue = cyc + 1;
                    end
                end
            end else if (frame_start) begin
                m_active = 1; m_idx = 0; m_pending = 0;
                m_next_issue = cyc + 1;
                frame_hs = 0;
            end
        end
    end

    // ---------------- full-width monitor ----------------
    int b_cnt = 0, b_fd = 0, b_issue = 0;
    logic [19:0] b_last_xy = '0;

    always @(negedge clk) begin : monitor_b
        if (rst_n) begin
            if (pixel_valid_b === 1'b1) b_issue = cyc;
            if (frame_done_b === 1'b1) b_fd++;
            if (out_valid_b === 1'b1 && out_ready_b) begin
                check("b_x", pixel_x_b, b_cnt % BH);
                check("b_y", pixel_y_b, b_cnt / BH);
                check("b_rgb", {out_r_b, out_g_b, out_b_b}, col(b_issue + BLAT));
                check("b_sof_eol", {out_sof_b, out_eol_b}, {b_cnt == 0, (b_cnt % BH) == BH - 1});
                check("b_frame_done", frame_done_b, b_cnt == BH * BV - 1);
                b_last_xy = {pixel_x_b, pixel_y_b};
                b_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_pv(input int x, input int y, input int budget, input string tag);
        int n = 0;
        logic found;
        do begin
            @(negedge clk);
            n++;
            found = (pixel_valid === 1'b1) && (pixel_x == 10'(x)) && (pixel_y == 10'(y));
        end while (!found && n < budget);
        check(tag, found, 1'b1);
    endtask

    task automatic wait_ov(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < budget);
        check(tag, out_valid, 1'b1);
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (m_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, m_frames, target);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int n;
        rst_n = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
        frame_start_b = 1'b0; out_ready_b = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2 + $urandom_range(0, 3));

        // Frame 1: downstream always ready.
        pulse_start();
        wait_frames(1, 400, "f1_done");
        step(3);
        check("f1_outputs", frame_hs, AH * AV);

        // Frame 2: stall on pixel 2, stray start during pixel 3 and with frame_done.
        step($urandom_range(1, 5));
        pulse_start();
        wait_pv(2, 0, 200, "f2_pv2");
        step(1);
        out_ready = 1'b0;
        wait_ov(100, "f2_ov2");
        step(50);
        out_ready = 1'b1;
        wait_pv(3, 0, 200, "f2_pv3");
        step($urandom_range(2, 15));
        pulse_start();
        wait_pv(AH - 1, AV - 1, 400, "f2_pv_last");
        step(1);
        out_ready = 1'b0;
        wait_ov(100, "f2_ov_last");
        step(1);
        out_ready = 1'b1;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        wait_frames(2, 50, "f2_done");
        step(30);
        check("f2_outputs", frame_hs, AH * AV);

        // Frame 3: random backpressure.
        pulse_start();
        n = 0;
        while (m_frames < 3 && n < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step(1);
            n++;
        end
        out_ready = 1'b1;
        check("f3_done", m_frames, 3);
        check("f3_outputs", frame_hs, AH * AV);

        // Frame 4: reset during WAIT of pixel 5, then a fresh frame.
        step($urandom_range(1, 4));
        pulse_start();
        wait_pv(1, 1, 400, "f4_pv5");
        step($urandom_range(2, 15));
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(5);
        check("f4_no_done", m_frames, 3);
        pulse_start();
        wait_frames(4, 400, "f5_done");
        step(3);
        check("f5_outputs", frame_hs, AH * AV);
        check("fd_pulses", dut_fd_cnt, 4);

        // Full-width frame at minimum latency.
        frame_start_b = 1'b1;
        step(1);
        frame_start_b = 1'b0;
        n = 0;
        while (b_fd < 1 && n < 4000) begin
            step(1);
            n++;
        end
        step(5);
        check("b_handshakes", b_cnt, BH * BV);
        check("b_last_xy", b_last_xy, {10'(BH - 1), 10'(BV - 1)});
        check("b_fd_pulses", b_fd, 1);
        check("b_idle", busy_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_scan_driver.md
PIXEL_SCAN_DRIVER -- requirements
Module: pixel_scan_driver

Interface
REQ-001 Parameter H_RES, default 320, pixels per line.
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 Parameter CAPTURE_LAT, default 20, cycles from the pixel_valid pulse to the rgb sample; range 1..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 frame_start  input  1  one-cycle request to render one frame.
REQ-007 pixel_x  output  10  column of the current pixel request.
REQ-008 pixel_y  output  10  row of the current pixel request.
REQ-009 pixel_valid  output  1  one-cycle pulse that issues a pixel request to the raytracer.
REQ-010 rgb_r, rgb_g, rgb_b  input  8 each  shaded colour returned by the raytracer.
REQ-011 out_r, out_g, out_b  output  8 each  captured pixel colour.
REQ-012 out_valid  output  1  output pixel available.
REQ-013 out_ready  input  1  downstream accepts the output pixel.
REQ-014 out_sof  output  1  qualifies out_valid; high for pixel (0,0).
REQ-015 out_eol  output  1  qualifies out_valid; high for x = H_RES-1.
REQ-016 busy  output  1  high from frame acceptance until the last handshake.
REQ-017 frame_done  output  1  one-cycle pulse after the final pixel handshake.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT, HOLD.
- IDLE: goes to ISSUE on frame_start, with x=0, y=0.
- ISSUE: one cycle with pixel_valid=1; then WAIT, with the latency counter cleared.
- WAIT: counts cycles; on the cycle the count reaches CAPTURE_LAT-1, registers rgb into out_*, sets out_valid, and goes to HOLD.
- HOLD: waits for out_valid && out_ready.
REQ-019 The handshake in HOLD SHALL take effect in the same cycle it is seen.
- Not the last pixel: clear out_valid, advance the coordinates, go to ISSUE next cycle.
- Last pixel: go to IDLE and pulse frame_done.
REQ-020 pixel_x and pixel_y SHALL stay stable from ISSUE until the next coordinate advance.
REQ-021 The coordinates SHALL advance raster order.
- x increments each pixel.
- At x = H_RES-1, x wraps to 0 and y increments.
- The last pixel is x = H_RES-1, y = V_RES-1.
REQ-022 While out_valid=1 and out_ready=0, out_r/g/b, out_sof and out_eol SHALL stay stable; no new request is issued.
REQ-023 frame_start outside IDLE SHALL be ignored; there is no queuing.
REQ-024 frame_start in the same cycle as frame_done SHALL be ignored, because the FSM is not yet in IDLE.
REQ-025 At most one pixel request SHALL be outstanding; the minimum pixel period is CAPTURE_LAT+2 cycles.
REQ-026 The latency counter SHALL be 8 bits; the coordinate counters SHALL be 10 bits, with no overflow for legal parameters.
REQ-027 busy SHALL be high in ISSUE, WAIT and HOLD, and low in IDLE.

Reset
REQ-028 On rst_n=0 at a clock edge, the block SHALL enter IDLE, abandoning any frame in progress with no frame_done.
REQ-029 Reset values SHALL be: pixel_x=0, pixel_y=0, pixel_valid=0, out_valid=0, out_r/g/b=0, out_sof=0, out_eol=0, busy=0, frame_done=0, latency counter=0.
REQ-030 The first frame_start after rst_n returns high SHALL be accepted normally.

Structure
REQ-031 A shared raytracer package SHALL hold: the resolution constants 320 and 240, the default CAPTURE_LAT, and the FSM state enum type.
REQ-032 One sub-module, raster_counter, SHALL hold the x/y counters, the wrap logic and the last-pixel and end-of-line flags; the FSM and capture logic stay at top level.

Verification
REQ-033 Reset, then frame_start, with out_ready held at 1 and H_RES=4, V_RES=2 -> required response:
- 8 pixel_valid pulses, spaced 22 cycles apart.
- Coordinates in the order (0,0) (1,0) (2,0) (3,0) (0,1) .. (3,1).
- out_sof on the first output only; out_eol on the 4th and 8th outputs.
- One frame_done pulse, then busy=0.
REQ-034 Drive rgb with a value equal to the cycle count; capture SHALL sample rgb exactly 20 cycles after pixel_valid.
REQ-035 Hold out_ready low for 50 cycles on pixel 2 -> out_* stable for the whole stall, no pixel_valid during it, and the next issue one cycle after the handshake.
REQ-036 Pulse frame_start again during pixel 3, and again together with frame_done -> both are ignored, and only 8 outputs are seen.
REQ-037 Assert rst_n=0 for one cycle during WAIT of pixel 5 -> all outputs take their reset values on the next cycle, no frame_done, and a new frame then starts at (0,0).
REQ-038 Run the default 320x240 frame -> 76800 handshakes, the last at (319,239), and exactly one frame_done.
